// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// IF-stage next-PC generator. Holds the architectural fetch PC, presents it to
// the BTB and instruction memory, selects the next PC (EX redirect, BTB
// predicted target, or PC+4) and registers the fetched PC together with its
// prediction into the IF/ID slot.
//
// Optional feature: define FETCH_BHT_EN to qualify BTB hits with a table of
// 2-bit saturating direction counters. Without it a BTB hit is always taken.
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  output logic [31:0] btb_pc,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        bht_upd_en,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken,
  output logic        fd_valid,
  output logic [31:0] fd_pc,
  output logic        fd_pred_taken,
  output logic [31:0] fd_pred_target
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_pred_taken_q, fd_pred_taken_d;
  logic [31:0] fd_pred_target_q, fd_pred_target_d;

  logic        pred_taken;
  logic [31:0] pred_next;
  logic [31:0] pc_plus4;
  logic        accept;

  // Low address bits of targets are forced to word alignment, so they are dropped.
  logic        unused_low_bits;
  assign unused_low_bits = ^{btb_target[1:0], redirect_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Direction prediction
  // ---------------------------------------------------------------------------
`ifdef FETCH_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;

  assign lkp_idx = pc_q[IDX_W+1:2];
  assign upd_idx = bht_upd_pc[IDX_W+1:2];

  // Only the index bits of the update PC select a counter.
  logic unused_bht_pc;
  assign unused_bht_pc = ^{bht_upd_pc[31:IDX_W+2], bht_upd_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign pred_taken = btb_hit && bht_q[lkp_idx][1];

  // Saturating counter update from resolved conditional branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this table is reset entry by entry because predictions must start
      // weakly not-taken; that costs a reset on every counter, which is why it
      // is built from flops rather than an SRAM macro.
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_upd_en) begin
      if (bht_upd_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end
`else
  // Without the BHT every BTB hit is predicted taken and updates are ignored.
  assign pred_taken = btb_hit;

  logic unused_bht;
  assign unused_bht = ^{bht_upd_en, bht_upd_pc, bht_upd_taken};
`endif

  // ---------------------------------------------------------------------------
  // Request and next-PC selection
  // ---------------------------------------------------------------------------
  assign imem_addr = pc_q;
  assign btb_pc    = pc_q;
  assign imem_req  = (state_q == ST_RUN) && !stall_if;
  assign accept    = imem_req && imem_gnt;
  assign pc_plus4  = pc_q + 32'd4;
  assign pred_next = pred_taken ? {btb_target[31:2], 2'b00} : pc_plus4;

  // Next-state logic: redirect always resumes fetching, boot lasts one cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (redirect_en) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  state_d = stall_if ? ST_HOLD : ST_RUN;
        ST_HOLD: state_d = stall_if ? ST_HOLD : ST_RUN;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // PC and IF/ID slot update: redirect > stall > accepted fetch > bubble.
  always_comb begin
    pc_d             = pc_q;
    fd_valid_d       = fd_valid_q;
    fd_pc_d          = fd_pc_q;
    fd_pred_taken_d  = fd_pred_taken_q;
    fd_pred_target_d = fd_pred_target_q;

    if (redirect_en) begin
      // Any grant this cycle is dropped; ID ignores it because fd_valid clears.
      pc_d             = {redirect_pc[31:2], 2'b00};
      fd_valid_d       = 1'b0;
      fd_pred_taken_d  = 1'b0;
      fd_pred_target_d = 32'd0;
    end else if (stall_if) begin
      // ID is full: everything holds.
    end else if (accept) begin
      pc_d             = pred_next;
      fd_valid_d       = 1'b1;
      fd_pc_d          = pc_q;
      fd_pred_taken_d  = pred_taken;
      fd_pred_target_d = pred_taken ? pred_next : 32'd0;
    end else begin
      // ID consumed the slot but nothing new arrived: insert a bubble.
      fd_valid_d       = 1'b0;
    end
  end

  // State, PC and IF/ID slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_BOOT;
      pc_q             <= RESET_PC;
      fd_valid_q       <= 1'b0;
      fd_pc_q          <= 32'd0;
      fd_pred_taken_q  <= 1'b0;
      fd_pred_target_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q          <= state_d;
      pc_q             <= pc_d;
      fd_valid_q       <= fd_valid_d;
      fd_pc_q          <= fd_pc_d;
      fd_pred_taken_q  <= fd_pred_taken_d;
      fd_pred_target_q <= fd_pred_target_d;
    end
  end

  assign fd_valid       = fd_valid_q;
  assign fd_pc          = fd_pc_q;
  assign fd_pred_taken  = fd_pred_taken_q;
  assign fd_pred_target = fd_pred_target_q;

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
IF-stage next-PC generator directly upstream of the BTB and instruction memory. Holds the architectural fetch PC and drives it to the BTB lookup port and the imem request port. Selects the next PC from EX redirect, BTB-predicted target or PC+4. Registers the fetched PC plus its prediction into the IF/ID slot so EX can detect mispredicts.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
BHT_ENTRIES, 256, number of 2-bit counters; power of two; used only with FETCH_BHT_EN.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall_if  in  1  downstream (ID) cannot accept; hold PC and IF/ID slot
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc_q)
imem_gnt  in  1  imem accepts request this cycle
btb_pc  out  32  BTB query PC (= pc_q)
btb_hit  in  1  BTB hit for btb_pc (combinational)
btb_target  in  32  BTB predicted target
redirect_en  in  1  EX mispredict/flush
redirect_pc  in  32  correct PC from EX
bht_upd_en  in  1  resolved conditional branch (FETCH_BHT_EN only)
bht_upd_pc  in  32  PC of resolved branch
bht_upd_taken  in  1  actual outcome
fd_valid  out  1  IF/ID slot holds a valid fetch
fd_pc  out  32  PC of fetched instruction
fd_pred_taken  out  1  prediction used for fd_pc
fd_pred_target  out  32  predicted target (0 when not taken)

Behaviour:
- FSM states: BOOT, RUN, HOLD. Reset -> BOOT. BOOT -> RUN after 1 cycle (imem_req=0 in BOOT). RUN -> HOLD when stall_if=1; HOLD -> RUN when stall_if=0. redirect_en from any state -> RUN.
- Reset values: pc_q=RESET_PC, fd_valid=0, fd_pc=0, fd_pred_taken=0, fd_pred_target=0, imem_req=0.
- imem_addr=btb_pc=pc_q, combinational from register.
- imem_req=1 only in RUN with stall_if=0.
- pred_taken = btb_hit (see optional feature); pred_next = pred_taken ? {btb_target[31:2],2'b00} : pc_q+4; 32-bit add, FFFF_FFFC wraps to 0000_0000.
- Accept = imem_req && imem_gnt. On accept: pc_q<=pred_next; fd_valid<=1, fd_pc<=pc_q, fd_pred_taken<=pred_taken, fd_pred_target<=pred_taken?pred_next:0. Latency: PC to fd_pc 1 cycle.
- RUN, no grant, no stall: pc_q holds, fd_valid<=0 (bubble).
- stall_if=1: pc_q and all fd_* hold; no request.
- redirect_en=1: highest priority, overrides stall and grant: pc_q<={redirect_pc[31:2],2'b00}, fd_valid<=0, fd_pred_*<=0; a grant in that same cycle is discarded (data ignored by ID since fd_valid=0).
- Redirect during BOOT: pc_q takes redirect_pc, state -> RUN.
- rst mid-operation: all state to reset values immediately (async); in-flight fetch dropped.

Optional Feature:
FETCH_BHT_EN. Defined: BHT_ENTRIES x 2-bit saturating counters, index pc[log2(BHT_ENTRIES)+1:2], reset to 2'b01 (weakly not-taken); pred_taken = btb_hit && ctr[idx(pc_q)][1]; on bht_upd_en counter at idx(bht_upd_pc) increments (taken, saturate 3) or decrements (not taken, saturate 0). Same-cycle lookup and update of one index: lookup sees the old value. Not defined: pred_taken = btb_hit; bht_upd_* ignored; no counter storage.

Test Plan:
- Reset, RESET_PC=0, imem_gnt=1, btb_hit=0 -> BOOT 1 cycle with imem_req=0, then fd_pc sequence 0,4,8,C with fd_valid=1 each cycle.
- pc_q=0x100, btb_hit=1, btb_target=0x200 -> fd_pc=0x100, fd_pred_taken=1, fd_pred_target=0x200; next imem_addr=0x200 (FETCH_BHT_EN off).
- stall_if=1 for 3 cycles at fd_pc=0x8 -> fd_* and imem_addr frozen, imem_req=0; release -> fetch resumes at 0xC.
- redirect_en=1, redirect_pc=0x403 with stall_if=1 and imem_gnt=1 -> next cycle fd_valid=0, imem_addr=0x400, imem_req=1.
- imem_gnt=0 for 2 cycles at pc 0x20 -> fd_valid=0 both cycles, imem_addr stays 0x20; pc 0xFFFF_FFFC granted -> next imem_addr=0x0.
- FETCH_BHT_EN: btb_hit=1 at 0x40 after reset -> pred_taken=0; two bht_upd taken at 0x40 -> pred_taken=1; two not-taken -> pred_taken=0.
